tetris_piece_controller: RTL

Sequences one falling tetrimino on the 8x8 LED playfield. It requests a piece shape from tetrimino_creator by driving its 3-bit type select, then latches the returned 8x8 pattern. It applies move and gravity commands with collision checks, locks the piece into the board, and clears full rows. It drives the composite frame (board OR active piece) to the LED matrix scanner.

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/tetris_piece_controller_if.sv | 19 +
 rtl/tetris_collision_check.sv | 44 ++++
 rtl/tetris_piece_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the tetris playfield controller: row/matrix shapes,
// piece type codes, controller states and shift directions.
package tetris_pkg;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;

    typedef logic [COLS-1:0]           row_t;
    typedef logic [ROWS-1:0][COLS-1:0] matrix_t;
    typedef logic [2:0]                piece_type_t;

    localparam piece_type_t TYPE_NONE = 3'b000;
    localparam piece_type_t TYPE_L    = 3'b001;
    localparam piece_type_t TYPE_O    = 3'b010;
    localparam piece_type_t TYPE_S    = 3'b011;
    localparam piece_type_t TYPE_T    = 3'b100;
    localparam piece_type_t TYPE_Z    = 3'b101;
    localparam piece_type_t TYPE_I    = 3'b110;
    localparam piece_type_t TYPE_J    = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN_REQ,
        SPAWN_LOAD,
        FALL,
        LOCK,
        CLEAR,
        OVER
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DIR_LEFT,
        DIR_RIGHT,
        DIR_DOWN
    } dir_t;

    // True when any lit cell of a coincides with a lit cell of b.
    function automatic logic overlaps(matrix_t a, matrix_t b);
        return |(a & b);
    endfunction

    // A row with every column lit is ready to be cleared.
    function automatic logic row_full(row_t r);
        return &r;
    endfunction

endpackage

// File: rtl/tetris_piece_controller_if.sv
// Piece request/response link between the controller and tetrimino_creator:
// the controller selects a type, the creator answers combinationally with its 8x8 pattern.
interface tetris_piece_controller_if;
    import tetris_pkg::*;

    piece_type_t piece_type;
    matrix_t     piece_pattern;

    modport master (
        output piece_type,
        input  piece_pattern
    );

    modport slave (
        input  piece_type,
        output piece_pattern
    );

endinterface

// File: rtl/tetris_collision_check.sv
// Combinational one-step shift of the active piece with range and board-overlap check.
module tetris_collision_check
    import tetris_pkg::*;
(
    input  matrix_t piece,
    input  matrix_t board,
    input  dir_t    dir,
    output matrix_t shifted_c,
    output logic    blocked_c
);

    logic out_of_range;

    // A bit leaving the field on the shifted edge means the move is illegal.
    always_comb begin
        shifted_c    = '0;
        out_of_range = 1'b0;
        unique case (dir)
            DIR_LEFT: begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    shifted_c[r] = piece[r] << 1;
                    out_of_range = out_of_range | piece[r][COLS-1];
                end
            end
            DIR_RIGHT: begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    shifted_c[r] = piece[r] >> 1;
                    out_of_range = out_of_range | piece[r][0];
                end
            end
            DIR_DOWN: begin
                for (int r = 1; r < int'(ROWS); r++) begin
                    shifted_c[r] = piece[r-1];
                end
                out_of_range = |piece[ROWS-1];
            end
            default: begin
                shifted_c = piece;
            end
        endcase
        blocked_c = out_of_range | overlaps(shifted_c, board);
    end

endmodule

// File: rtl/tetris_piece_controller.sv
// Falling-piece sequencer for the 8x8 LED playfield: spawns, moves, drops,
// locks and clears rows, and drives the composite frame to the scanner.
module tetris_piece_controller
    import tetris_pkg::*;
#(
    parameter int unsigned LINES_W        = 8,
    parameter piece_type_t SPAWN_FALLBACK = TYPE_O
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      tick,
    input  logic                      move_left,
    input  logic                      move_right,
    input  piece_type_t               next_type,
    tetris_piece_controller_if.master creator,
    output matrix_t                   display,
    output logic [LINES_W-1:0]        lines_cleared,
    output logic                      game_over,
    output logic                      busy
);

    ctrl_state_t state;
    matrix_t     board;
    matrix_t     piece;
    logic [2:0]  scan_row;
    logic        pending_tick;

    logic        any_move;
    logic        one_move;
    dir_t        dir;
    matrix_t     shifted;
    logic        blocked;

    assign any_move = move_left | move_right;
    assign one_move = move_left ^ move_right;

    // Single checker: a lone move selects its direction, otherwise evaluate gravity.
    always_comb begin
        dir = DIR_DOWN;
        if (move_left && !move_right) begin
            dir = DIR_LEFT;
        end else if (move_right && !move_left) begin
            dir = DIR_RIGHT;
        end
    end

    tetris_collision_check u_collision (
        .piece     (piece),
        .board     (board),
        .dir       (dir),
        .shifted_c (shifted),
        .blocked_c (blocked)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            board              <= '0;
            piece              <= '0;
            scan_row           <= 3'd0;
            pending_tick       <= 1'b0;
            creator.piece_type <= TYPE_NONE;
            display            <= '0;
            lines_cleared      <= '0;
            game_over          <= 1'b0;
            busy               <= 1'b0;
        end else begin
            display <= board | piece;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SPAWN_REQ;
                        busy  <= 1'b1;
                    end
                end

                SPAWN_REQ: begin
                    creator.piece_type <= (next_type == TYPE_NONE) ? SPAWN_FALLBACK : next_type;
                    state              <= SPAWN_LOAD;
                end

                // Pattern answers the type selected last cycle; overlap on entry ends the game.
                SPAWN_LOAD: begin
                    busy <= 1'b0;
                    if (overlaps(creator.piece_pattern, board)) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        piece <= creator.piece_pattern;
                        state <= FALL;
                    end
                end

                // Moves take priority; a tick that collides with one is deferred.
                FALL: begin
                    if (any_move) begin
                        if (one_move && !blocked) begin
                            piece <= shifted;
                        end
                        if (tick) begin
                            pending_tick <= 1'b1;
                        end
                    end else if (tick || pending_tick) begin
                        pending_tick <= 1'b0;
                        if (blocked) begin
                            state <= LOCK;
                            busy  <= 1'b1;
                        end else begin
                            piece <= shifted;
                        end
                    end
                end

                LOCK: begin
                    board    <= board | piece;
                    piece    <= '0;
                    scan_row <= 3'd7;
                    state    <= CLEAR;
                end

                // Collapse a full row and re-check the same index, since new content dropped into it.
                CLEAR: begin
                    if (row_full(board[scan_row])) begin
                        for (int r = 1; r < int'(ROWS); r++) begin
                            if (3'(r) <= scan_row) begin
                                board[r] <= board[r-1];
                            end
                        end
                        board[0] <= '0;
                        if (lines_cleared != '1) begin
                            lines_cleared <= lines_cleared + LINES_W'(1);
                        end
                    end else if (scan_row == 3'd0) begin
                        state <= SPAWN_REQ;
                    end else begin
                        scan_row <= scan_row - 3'd1;
                    end
                end

                OVER: begin
                    piece <= '0;
                    if (start) begin
                        board         <= '0;
                        lines_cleared <= '0;
                        game_over     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= SPAWN_REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
